// File: rtl/O_BUF_DS.sv
// Behavioural model of the differential output pad driver primitive.
// The weak keeper only matters at the physical pad, so both variants drive the same logical values.
module O_BUF_DS #(
   parameter WEAK_KEEPER = "NONE"
) (
   input  logic I,
   output logic O_P,
   output logic O_N
);

   generate
      if (WEAK_KEEPER == "NONE") begin : g_plain
         assign O_P = I;
         assign O_N = ~I;
      end else begin : g_keeper
         assign O_P = I;
         assign O_N = ~I;
      end
   endgenerate

endmodule

// File: rtl/differential_tx.sv
// Source-synchronous differential transmitter: frames parallel words as START/data/PARITY/STOP
// on a differential data pair, alongside a half-rate forwarded clock pair.
module differential_tx #(
   parameter int unsigned WIDTH       = 8,
   parameter              WEAK_KEEPER = "NONE"
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] DATA,
   input  logic             VALID,
   output logic             READY,
   output logic             BUSY,
   output logic             Q_p,
   output logic             Q_n,
   output logic             CLK_OUT_p,
   output logic             CLK_OUT_n
);

   localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic             fclk_q, fclk_d;
   logic             line_q, line_d;
   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             par_q, par_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fclk_q  <= 1'b0;
         line_q  <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         par_q   <= 1'b0;
      end else begin
         fclk_q  <= fclk_d;
         line_q  <= line_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         par_q   <= par_d;
      end
   end

   // Serial state moves only when fclk is high, so the line changes on the forwarded clock's falling edge.
   always_comb begin
      fclk_d  = ~fclk_q;
      line_d  = line_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      par_d   = par_q;
      READY   = fclk_q && ((state_q == S_IDLE) || (state_q == S_STOP));
      if (fclk_q) begin
         case (state_q)
            S_IDLE, S_STOP: begin
               if (VALID) begin
                  state_d = S_START;
                  line_d  = 1'b0;
                  sr_d    = DATA;
                  par_d   = ^DATA;
                  cnt_d   = '0;
               end else begin
                  state_d = S_IDLE;
                  line_d  = 1'b1;
               end
            end
            S_START: begin
               state_d = S_DATA;
               line_d  = sr_q[0];
               sr_d    = sr_q >> 1;
            end
            S_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = S_PARITY;
                  line_d  = par_q;
               end else begin
                  line_d = sr_q[0];
                  sr_d   = sr_q >> 1;
                  cnt_d  = cnt_q + CW'(1);
               end
            end
            S_PARITY: begin
               state_d = S_STOP;
               line_d  = 1'b1;
            end
            default: begin
               state_d = S_IDLE;
               line_d  = 1'b1;
            end
         endcase
      end
   end

   assign BUSY = (state_q != S_IDLE);

   O_BUF_DS #(.WEAK_KEEPER(WEAK_KEEPER)) u_q_buf (
      .I   (line_q),
      .O_P (Q_p),
      .O_N (Q_n)
   );

   O_BUF_DS #(.WEAK_KEEPER(WEAK_KEEPER)) u_clk_buf (
      .I   (fclk_q),
      .O_P (CLK_OUT_p),
      .O_N (CLK_OUT_n)
   );

endmodule

// File: tb/tb_differential_tx.sv
// Bench for differential_tx: expected slot bits are queued when a word is sent and popped
// as the serial line is sampled on each forwarded-clock rising edge.
module tb_differential_tx;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, valid, ready, busy, q_p, q_n, co_p, co_n;
   logic [7:0] data;
   logic       rst1_n, valid1, ready1, busy1, q1_p, q1_n, co1_p, co1_n;
   logic [0:0] data1;

   differential_tx #(.WIDTH(8), .WEAK_KEEPER("NONE")) u_dut8 (
      .CLK(clk), .RST_N(rst_n), .DATA(data), .VALID(valid), .READY(ready), .BUSY(busy),
      .Q_p(q_p), .Q_n(q_n), .CLK_OUT_p(co_p), .CLK_OUT_n(co_n)
   );

   differential_tx #(.WIDTH(1), .WEAK_KEEPER("NONE")) u_dut1 (
      .CLK(clk), .RST_N(rst1_n), .DATA(data1), .VALID(valid1), .READY(ready1), .BUSY(busy1),
      .Q_p(q1_p), .Q_n(q1_n), .CLK_OUT_p(co1_p), .CLK_OUT_n(co1_n)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int t_acc = 0;
   bit exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push_frame(input logic [31:0] d, input int w);
      bit p;
      p = 1'b0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < w; i++) begin
         exp_q.push_back(d[i]);
         p ^= d[i];
      end
      exp_q.push_back(p);
      exp_q.push_back(1'b1);
   endfunction

   // Offer a word on the 8-bit DUT and return just after the accepting edge.
   task automatic send8(input logic [7:0] d, input bit keep_valid);
      int n;
      n = 0;
      data  = d;
      valid = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready && n < 40);
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL send8_ready_timeout: ready=%b required=1", ready);
      end
      @(posedge clk); #1;
      t_acc = cyc;
      if (!keep_valid) valid = 1'b0;
   endtask

   // Sample nslots slots; drop VALID after drop_after further acceptances.
   task automatic drain8(input int nslots, input int drop_after);
      int  got, acc, n;
      bit  drop_pending, e;
      got = 0; acc = 0; n = 0; drop_pending = 1'b0;
      while (got < nslots && n < 400) begin
         @(posedge clk); #1;
         n++;
         if (drop_pending) begin
            valid = 1'b0;
            drop_pending = 1'b0;
         end
         if (co_p === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            vectors++;
            if (q_p !== e) begin
               miscompares++;
               $display("FAIL slot%0d_q_p: got %b required %b", got, q_p, e);
            end
            vectors++;
            if (q_n !== ~e) begin
               miscompares++;
               $display("FAIL slot%0d_q_n: got %b required %b", got, q_n, ~e);
            end
            got++;
            if (valid && ready) begin
               acc++;
               if (acc >= drop_after) drop_pending = 1'b1;
            end
         end
      end
      if (drop_pending) begin
         @(posedge clk); #1;
         valid = 1'b0;
      end
      vectors++;
      if (got != nslots) begin
         miscompares++;
         $display("FAIL drain8_timeout: got %0d slots required %0d", got, nslots);
      end
   endtask

   task automatic test_reset();
      bit ef;
      rst_n = 1'b0; rst1_n = 1'b0;
      valid = 1'b0; valid1 = 1'b0; data = '0; data1 = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({q_p, q_n, co_p, co_n, ready, busy} !== 6'b100100) begin
         miscompares++;
         $display("FAIL reset_pads: got %b required 100100", {q_p, q_n, co_p, co_n, ready, busy});
      end
      vectors++;
      if ({q1_p, q1_n, co1_p, co1_n, ready1, busy1} !== 6'b100100) begin
         miscompares++;
         $display("FAIL reset_pads_w1: got %b required 100100",
                  {q1_p, q1_n, co1_p, co1_n, ready1, busy1});
      end
      rst_n = 1'b1; rst1_n = 1'b1;
      ef = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         ef = ~ef;
         vectors++;
         if ({co_p, co_n} !== {ef, ~ef}) begin
            miscompares++;
            $display("FAIL idle_clk_out cyc%0d: got %b%b required %b%b", i, co_p, co_n, ef, ~ef);
         end
         vectors++;
         if (ready !== ef) begin
            miscompares++;
            $display("FAIL idle_ready cyc%0d: got %b required %b", i, ready, ef);
         end
         vectors++;
         if ({q_p, q_n, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_line cyc%0d: got %b required 100", i, {q_p, q_n, busy});
         end
      end
   endtask

   task automatic test_single_a5();
      push_frame(32'hA5, 8);
      send8(8'hA5, 1'b0);
      drain8(11, 1);
      @(posedge clk); #1;
      vectors++;
      if ((cyc - t_acc) != 22 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL a5_duration: got %0d cycles busy=%b required 22 busy=0", cyc - t_acc, busy);
      end
   endtask

   task automatic test_back_to_back();
      push_frame(32'h07, 8);
      push_frame(32'hFF, 8);
      send8(8'h07, 1'b1);
      data = 8'hFF;
      drain8(22, 1);
      @(posedge clk); #1;
      vectors++;
      if ((cyc - t_acc) != 44 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_duration: got %0d cycles busy=%b required 44 busy=0", cyc - t_acc, busy);
      end
   endtask

   task automatic test_data_change();
      push_frame(32'h3C, 8);
      send8(8'h3C, 1'b0);
      data = 8'h00;
      drain8(11, 1);
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_midframe();
      push_frame(32'hA5, 8);
      send8(8'hA5, 1'b0);
      drain8(5, 1);
      @(posedge clk); #1;
      vectors++;
      if (q_p !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_slot4: got q_p=%b busy=%b required q_p=0 busy=1", q_p, busy);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({q_p, q_n, busy, ready, co_p} !== 5'b10000) begin
         miscompares++;
         $display("FAIL midframe_reset: got %b required 10000", {q_p, q_n, busy, ready, co_p});
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         vectors++;
         if ({q_p, q_n, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL post_reset_idle cyc%0d: got %b required 100", i, {q_p, q_n, busy});
         end
      end
      push_frame(32'hA5, 8);
      send8(8'hA5, 1'b0);
      drain8(11, 1);
      repeat (2) @(posedge clk);
   endtask

   task automatic test_width1();
      int  n, got;
      bit  e;
      push_frame(32'h1, 1);
      data1  = 1'b1;
      valid1 = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready1 && n < 40);
      @(posedge clk); #1;
      t_acc  = cyc;
      valid1 = 1'b0;
      got = 0; n = 0;
      while (got < 4 && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (co1_p === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            vectors++;
            if ({q1_p, q1_n} !== {e, ~e}) begin
               miscompares++;
               $display("FAIL w1_slot%0d: got %b%b required %b%b", got, q1_p, q1_n, e, ~e);
            end
            got++;
         end
      end
      @(posedge clk); #1;
      vectors++;
      if (got != 4 || (cyc - t_acc) != 8 || busy1 !== 1'b0) begin
         miscompares++;
         $display("FAIL w1_duration: got %0d slots %0d cycles busy=%b required 4 slots 8 cycles busy=0",
                  got, cyc - t_acc, busy1);
      end
   endtask

   initial begin
      test_reset();
      test_single_a5();
      test_back_to_back();
      test_data_change();
      test_reset_midframe();
      test_width1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
